// File: rtl/matmul_pkg.sv
// Shared defaults and FSM state type for the sequential matrix-multiply block.
package matmul_pkg;

  localparam int N_DEF  = 4;
  localparam int DW_DEF = 8;
  localparam int OW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index width for a counter or table of n entries (never zero bits wide).
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Shared multiply-accumulate datapath: one DW x DW multiplier feeding an OW-bit accumulator.
// Define MATMUL_SAT_EN to saturate the accumulator at 2^OW-1 instead of wrapping.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          flush,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [OW-1:0] sum
);

  localparam int PW = 2 * DW;

  logic [PW-1:0] prod_s;
  logic [OW-1:0] acc_r;

  assign prod_s = a * b;

`ifdef MATMUL_SAT_EN
  localparam int SW = ((OW > PW) ? OW : PW) + 1;
  localparam logic [SW-1:0] SAT_MAX = {{(SW - OW){1'b0}}, {OW{1'b1}}};

  logic [SW-1:0] wide_s;

  assign wide_s = SW'(acc_r) + SW'(prod_s);

  // Clamp the running sum; addends are unsigned so clamping each step equals clamping the total.
  always_comb begin
    sum = wide_s[OW-1:0];
    if (wide_s > SAT_MAX) begin
      sum = {OW{1'b1}};
    end else begin
      sum = wide_s[OW-1:0];
    end
  end
`else
  // Modulo-2^OW running sum.
  always_comb begin
    sum = acc_r + OW'(prod_s);
  end
`endif

  // Accumulator: cleared on a new operation and after each finished dot product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= '0;
    end else if (clr) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= flush ? '0 : sum;
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for C = A x B using one shared MAC, one product per cycle (k innermost, then j, then i).
// Accumulator overflow mode is selected by the MATMUL_SAT_EN macro inside matmul_mac.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N*N*DW-1:0] A_flat,
  input  logic [N*N*DW-1:0] B_flat,
  output logic              busy,
  output logic              done,
  output logic [N*N*OW-1:0] C_flat
);

  localparam int CW = idx_bits(N);
  localparam int IW = idx_bits(N * N);
  localparam logic [CW-1:0] K_MAX = CW'(N - 1);

  state_t        state_r;
  logic [DW-1:0] a_r [N*N];
  logic [DW-1:0] b_r [N*N];
  logic [OW-1:0] res_r [N*N];
  logic [CW-1:0] i_r;
  logic [CW-1:0] j_r;
  logic [CW-1:0] k_r;

  logic [IW-1:0] a_idx_s;
  logic [IW-1:0] b_idx_s;
  logic [IW-1:0] c_idx_s;
  logic [OW-1:0] sum_s;
  logic          mac_clr_s;
  logic          mac_en_s;
  logic          row_end_s;
  logic          last_s;

  assign a_idx_s   = IW'(int'(i_r) * N + int'(k_r));
  assign b_idx_s   = IW'(int'(k_r) * N + int'(j_r));
  assign c_idx_s   = IW'(int'(i_r) * N + int'(j_r));
  assign mac_clr_s = (state_r == IDLE) && start;
  assign mac_en_s  = (state_r == RUN);
  assign row_end_s = (k_r == K_MAX);
  assign last_s    = row_end_s && (j_r == K_MAX) && (i_r == K_MAX);

  matmul_mac #(
    .DW(DW),
    .OW(OW)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr  (mac_clr_s),
    .en   (mac_en_s),
    .flush(row_end_s),
    .a    (a_r[a_idx_s]),
    .b    (b_r[b_idx_s]),
    .sum  (sum_s)
  );

  // Control FSM with operand capture, index counters, result table and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      C_flat  <= '0;
      i_r     <= '0;
      j_r     <= '0;
      k_r     <= '0;
      for (int e = 0; e < N*N; e++) begin
        a_r[e]   <= '0;
        b_r[e]   <= '0;
        res_r[e] <= '0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int e = 0; e < N*N; e++) begin
              a_r[e] <= A_flat[e*DW +: DW];
              b_r[e] <= B_flat[e*DW +: DW];
            end
            i_r     <= '0;
            j_r     <= '0;
            k_r     <= '0;
            state_r <= RUN;
            busy    <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          if (row_end_s) begin
            res_r[c_idx_s] <= sum_s;
            k_r            <= '0;
            if (j_r == K_MAX) begin
              j_r <= '0;
              i_r <= (i_r == K_MAX) ? '0 : i_r + CW'(1'b1);
            end else begin
              j_r <= j_r + CW'(1'b1);
            end
          end else begin
            k_r <= k_r + CW'(1'b1);
          end
          // The final element is still in flight, so it is taken straight from the MAC.
          if (last_s) begin
            for (int e = 0; e < N*N; e++) begin
              C_flat[e*OW +: OW] <= (e == N*N - 1) ? sum_s : res_r[e];
            end
            state_r <= DONE;
            done    <= 1'b1;
          end else begin
            done <= 1'b0;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Randomized self-checking bench for matmul_seq_ctrl against a plain-arithmetic matrix model.
// Build with +define+MATMUL_SAT_EN to check the saturating variant.
module tb_matmul_seq_ctrl;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int OW   = 16;
  localparam int AW   = N * N * DW;
  localparam int CWID = N * N * OW;
  localparam int RUNC = N * N * N;

  logic            clk;
  logic            rst;
  logic            start;
  logic [AW-1:0]   A_flat;
  logic [AW-1:0]   B_flat;
  logic            busy;
  logic            done;
  logic [CWID-1:0] C_flat;

  int vec_cnt;
  int err_cnt;
  logic [CWID-1:0] last_c;

  matmul_seq_ctrl #(.N(N), .DW(DW), .OW(OW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A_flat(A_flat),
    .B_flat(B_flat),
    .busy  (busy),
    .done  (done),
    .C_flat(C_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: C(i,j) = sum_k A(i,k)*B(k,j), then wrapped or clamped to OW bits.
  function automatic logic [CWID-1:0] model(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [CWID-1:0] c;
    longint unsigned s, x, y, lim;
    lim = (64'd1 << OW) - 64'd1;
    c = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 64'd0;
        for (int k = 0; k < N; k++) begin
          x = 64'(a[(i*N+k)*DW +: DW]);
          y = 64'(b[(k*N+j)*DW +: DW]);
          s = s + x * y;
        end
`ifdef MATMUL_SAT_EN
        if (s > lim) s = lim;
`else
        s = s & lim;
`endif
        c[(i*N+j)*OW +: OW] = OW'(s);
      end
    end
    return c;
  endfunction

  function automatic logic [AW-1:0] rand_mat(input int unsigned max);
    logic [AW-1:0] m;
    for (int e = 0; e < N*N; e++) m[e*DW +: DW] = DW'($urandom_range(max, 0));
    return m;
  endfunction

  task automatic check_c(input string tag, input logic [CWID-1:0] exp);
    for (int e = 0; e < N*N; e++) begin
      check_eq($sformatf("%s_c%0d", tag, e), 64'(C_flat[e*OW +: OW]), 64'(exp[e*OW +: OW]));
    end
  endtask

  // One complete operation with mid-run operand scrambling and an ignored start during RUN.
  task automatic do_op(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input bit poke_done);
    logic [CWID-1:0] exp_c;
    int cyc, busy_cyc;
    exp_c = model(a, b);
    A_flat = a;
    B_flat = b;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    A_flat = ~a;
    B_flat = rand_mat(255);
    cyc = 0;
    busy_cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy === 1'b1) busy_cyc++;
      if (cyc == 20) start = 1'b1;
      if (cyc == 21) start = 1'b0;
      if (cyc == 30) check_eq({tag, "_hold_prev"}, 64'(C_flat == last_c), 64'd1);
      @(posedge clk); #1;
      cyc++;
    end
    check_eq({tag, "_latency"}, 64'(cyc), 64'(RUNC));
    check_eq({tag, "_busy_done"}, 64'(busy), 64'd1);
    if (busy === 1'b1) busy_cyc++;
    check_c(tag, exp_c);
    if (poke_done) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
    check_eq({tag, "_idle"}, 64'(busy), 64'd0);
    check_eq({tag, "_busy_len"}, 64'(busy_cyc), 64'(RUNC + 1));
    @(posedge clk); #1;
    check_eq({tag, "_stay_idle"}, 64'(busy), 64'd0);
    check_eq({tag, "_c_held"}, 64'(C_flat == exp_c), 64'd1);
    last_c = exp_c;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ma, mb, a1, b1, a2, b2;
    logic [CWID-1:0] e1, e2;
    int cyc, first, second, dcount;

    vec_cnt = 0;
    err_cnt = 0;
    last_c  = '0;
    rst     = 1'b1;
    start   = 1'b0;
    A_flat  = '0;
    B_flat  = '0;
    #2;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_c", 64'(C_flat == '0), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1..16 row-major for both operands
    for (int e = 0; e < N*N; e++) ma[e*DW +: DW] = DW'(e + 1);
    do_op("seq", ma, ma, 1'b0);
    check_eq("seq_c00", 64'(C_flat[0*OW +: OW]), 64'd90);
    check_eq("seq_c01", 64'(C_flat[1*OW +: OW]), 64'd100);
    check_eq("seq_c02", 64'(C_flat[2*OW +: OW]), 64'd110);
    check_eq("seq_c03", 64'(C_flat[3*OW +: OW]), 64'd120);
    check_eq("seq_c33", 64'(C_flat[15*OW +: OW]), 64'd600);

    // identity x 1..16, with a start poked during the DONE cycle
    mb = '0;
    for (int i = 0; i < N; i++) mb[(i*N+i)*DW +: DW] = DW'(1);
    do_op("ident", mb, ma, 1'b1);
    for (int e = 0; e < N*N; e++) check_eq("ident_val", 64'(C_flat[e*OW +: OW]), 64'(e + 1));

    // all-255 overflow corner
    ma = '1;
    do_op("max", ma, ma, 1'b0);
`ifdef MATMUL_SAT_EN
    check_eq("max_c00", 64'(C_flat[0 +: OW]), 64'd65535);
`else
    check_eq("max_c00", 64'(C_flat[0 +: OW]), 64'd63492);
`endif

    for (int t = 0; t < 6; t++) begin
      do_op($sformatf("rnd%0d", t), rand_mat((t % 2 == 0) ? 255 : 15),
            rand_mat((t % 3 == 0) ? 255 : 31), t[0]);
    end

    // start held high: back-to-back operations, operands changed mid-run
    a1 = rand_mat(255); b1 = rand_mat(255);
    a2 = rand_mat(255); b2 = rand_mat(255);
    e1 = model(a1, b1);
    e2 = model(a2, b2);
    A_flat = a1; B_flat = b1; start = 1'b1;
    @(posedge clk); #1;
    A_flat = a2; B_flat = b2;
    cyc = 0; first = -1; second = -1;
    while (second < 0 && cyc < 400) begin
      if (done === 1'b1) begin
        if (first < 0) begin
          first = cyc;
          check_c("b2b_first", e1);
        end else begin
          second = cyc;
          check_c("b2b_second", e2);
        end
      end
      if (cyc == 70) begin
        start = 1'b0;
        A_flat = ~a2;
        B_flat = ~b2;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check_eq("b2b_latency", 64'(first), 64'(RUNC));
    check_eq("b2b_period", 64'(second - first), 64'(RUNC + 2));
    cyc = 0;
    while (busy === 1'b1 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("b2b_idle", 64'(busy), 64'd0);
    last_c = e2;

    // reset in RUN cycle 30 aborts without a done pulse
    A_flat = rand_mat(255); B_flat = rand_mat(255); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) begin
      @(posedge clk); #1;
    end
    check_eq("abort_running", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    check_eq("abort_c", 64'(C_flat == '0), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    dcount = 0;
    for (int c = 0; c < 80; c++) begin
      if (done === 1'b1 || busy === 1'b1) dcount++;
      @(posedge clk); #1;
    end
    check_eq("abort_no_done", 64'(dcount), 64'd0);
    last_c = '0;
    do_op("post_rst", rand_mat(255), rand_mat(255), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
